// File: rtl/add_pkg.sv
// Shared types and arithmetic for the add responder: response record, occupancy
// states and the signed add-with-overflow used when a request is accepted.
package add_pkg;

  localparam int ADD_WIDTH = 32;

  typedef struct packed {
    logic [ADD_WIDTH-1:0] result;
    logic                 ovf;
  } rsp_t;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_state_t;

  // Overflow when both operands share a sign and the sum's sign differs.
  function automatic logic ovf_bit(input logic sign_a, input logic sign_b,
                                   input logic sign_sum);
    return (sign_a == sign_b) && (sign_sum != sign_a);
  endfunction

  function automatic rsp_t add_with_ovf(input logic [ADD_WIDTH-1:0] a,
                                        input logic [ADD_WIDTH-1:0] b);
    rsp_t r;
    r.result = a + b;
    r.ovf    = ovf_bit(a[ADD_WIDTH-1], b[ADD_WIDTH-1], r.result[ADD_WIDTH-1]);
    return r;
  endfunction

endpackage

// File: rtl/add_rsp_fifo.sv
// In-order response buffer: synchronous write, registered occupancy state with
// EMPTY / PARTIAL / FULL decode, head entry visible on rdata.
module add_rsp_fifo
  import add_pkg::*;
#(
  parameter int DW    = 33,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output occ_state_t    state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          do_push;
  logic          do_pop;

  // Guard here too so the buffer stays consistent whatever the caller drives.
  assign do_push = push && (state != OCC_FULL);
  assign do_pop  = pop && (state != OCC_EMPTY);

  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // Storage is not reset; the EMPTY state masks it on the outputs.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      state  <= OCC_EMPTY;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      count <= count_next;
      full  <= (count_next == CW'(DEPTH));
      empty <= (count_next == '0);
      if (count_next == '0)              state <= OCC_EMPTY;
      else if (count_next == CW'(DEPTH)) state <= OCC_FULL;
      else                               state <= OCC_PARTIAL;
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/add_responder.sv
// Valid/ready adder: sums are computed at acceptance, buffered in order and
// returned on the response channel; txn_count tallies retired responses.
module add_responder
  import add_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_ovf,
  output logic [15:0]      txn_count
);

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // req_ready and rsp_valid decode registered occupancy only, so neither
  // channel combinationally depends on the other.

  localparam int DW = WIDTH + 1;

  logic [WIDTH-1:0] sum;
  logic             sum_ovf;
  logic [DW-1:0]    head;
  logic             full;
  logic             empty;
  occ_state_t       occ_state;
  logic             push;
  logic             pop;

  generate
    if (WIDTH == ADD_WIDTH) begin : g_pkg_add
      rsp_t r;
      always_comb r = add_with_ovf(req_a, req_b);
      assign sum     = r.result;
      assign sum_ovf = r.ovf;
    end else begin : g_any_add
      assign sum     = req_a + req_b;
      assign sum_ovf = ovf_bit(req_a[WIDTH-1], req_b[WIDTH-1], sum[WIDTH-1]);
    end
  endgenerate

  assign req_ready = !full;
  assign rsp_valid = (occ_state != OCC_EMPTY);
  assign push      = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;

  add_rsp_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({sum_ovf, sum}),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .state (occ_state)
  );

  assign rsp_result = empty ? '0 : head[WIDTH-1:0];
  assign rsp_ovf    = empty ? 1'b0 : head[WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      txn_count <= '0;
    else if (pop) txn_count <= txn_count + 16'd1;
  end

endmodule

// File: tb/tb_add_responder.sv
// Bench for add_responder: vector table, directed multi-cycle sequences and a
// randomized run against a queue-based reference of the response channel.
module tb_add_responder;

  localparam int W     = 32;
  localparam int DEPTH = 2;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [W-1:0]  req_a;
  logic [W-1:0]  req_b;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [W-1:0]  rsp_result;
  logic          rsp_ovf;
  logic [15:0]   txn_count;

  add_responder #(.WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_ovf    (rsp_ovf),
    .txn_count  (txn_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int exp_txn = 0;
  logic [W:0] exp_q[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         ovf;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_req(input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid = v;
    req_a     = a;
    req_b     = b;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #3;
    rst = 1'b0;
    exp_txn = 0;
    exp_q.delete();
    @(negedge clk);
  endtask

  // Reference sum: exact signed arithmetic in a wider integer, then truncate.
  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    longint s;
    logic o;
    logic [63:0] su;
    sa = a;
    sb = b;
    s  = longint'(sa) + longint'(sb);
    o  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    su = s;
    return {o, su[W-1:0]};
  endfunction

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h7FFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return W'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [W:0] e;
    vecs[0] = '{32'd10,        32'd20,        32'd30,        1'b0};
    vecs[1] = '{32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 1'b1};
    vecs[2] = '{32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 1'b0};
    vecs[3] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1};
    vecs[4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b1};
    vecs[5] = '{32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0};
    vecs[6] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0};
    vecs[7] = '{32'h4000_0000, 32'h4000_0000, 32'h8000_0000, 1'b1};

    rst = 1'b0;
    rsp_ready = 1'b0;
    drive_req(1'b0, '0, '0);
    @(negedge clk);
    do_reset();

    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_req_ready", req_ready, 1);
    chk("reset_txn", txn_count, 0);
    chk("reset_result", rsp_result, 0);
    chk("reset_ovf", rsp_ovf, 0);

    // Vector table: one transaction each, response visible one edge later.
    for (int i = 0; i < 8; i++) begin
      drive_req(1'b1, vecs[i].a, vecs[i].b);
      rsp_ready = 1'b1;
      step();
      drive_req(1'b0, $urandom, $urandom);
      rsp_ready = 1'b0;
      chk("vec_valid", rsp_valid, 1);
      chk("vec_result", rsp_result, vecs[i].res);
      chk("vec_ovf", rsp_ovf, vecs[i].ovf);
      rsp_ready = 1'b1;
      step();
      exp_txn++;
      rsp_ready = 1'b0;
      chk("vec_drained", rsp_valid, 0);
      chk("vec_txn", txn_count, exp_txn);
    end

    // Backpressure: fill, hold a third request, then drain in order.
    drive_req(1'b1, 32'd1, 32'd1);
    step();
    drive_req(1'b1, 32'd2, 32'd2);
    step();
    chk("bp_full_ready", req_ready, 0);
    drive_req(1'b1, 32'd3, 32'd3);
    step();
    step();
    chk("bp_hold_ready", req_ready, 0);
    chk("bp_hold_result", rsp_result, 2);
    rsp_ready = 1'b1;
    chk("bp_first", rsp_result, 2);
    step();
    exp_txn++;
    chk("bp_ready_again", req_ready, 1);
    chk("bp_second", rsp_result, 4);
    step();
    exp_txn++;
    drive_req(1'b0, '0, '0);
    chk("bp_third", rsp_result, 6);
    step();
    exp_txn++;
    rsp_ready = 1'b0;
    chk("bp_empty", rsp_valid, 0);
    chk("bp_txn", txn_count, exp_txn);

    // Simultaneous push and pop at occupancy 1.
    drive_req(1'b1, 32'd7, 32'd7);
    step();
    drive_req(1'b1, 32'd5, 32'd5);
    rsp_ready = 1'b1;
    chk("pp_head_before", rsp_result, 14);
    step();
    exp_txn++;
    drive_req(1'b0, '0, '0);
    rsp_ready = 1'b0;
    chk("pp_valid", rsp_valid, 1);
    chk("pp_ready", req_ready, 1);
    chk("pp_head_after", rsp_result, 10);
    chk("pp_txn", txn_count, exp_txn);
    rsp_ready = 1'b1;
    step();
    exp_txn++;
    rsp_ready = 1'b0;
    chk("pp_drained", rsp_valid, 0);

    // Asynchronous reset with two responses buffered.
    drive_req(1'b1, 32'd100, 32'd1);
    step();
    drive_req(1'b1, 32'd200, 32'd2);
    step();
    drive_req(1'b0, '0, '0);
    chk("ar_full", req_ready, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_valid", rsp_valid, 0);
    chk("ar_ready", req_ready, 1);
    chk("ar_txn", txn_count, 0);
    chk("ar_result", rsp_result, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_txn = 0;
    rsp_ready = 1'b1;
    step();
    step();
    chk("ar_no_stale", rsp_valid, 0);
    chk("ar_txn_after", txn_count, 0);
    rsp_ready = 1'b0;

    // Randomized traffic against the queue reference.
    exp_q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic v;
      logic r;
      logic [W-1:0] a;
      logic [W-1:0] b;
      chk("rnd_req_ready", req_ready, (exp_q.size() < DEPTH) ? 1 : 0);
      chk("rnd_rsp_valid", rsp_valid, (exp_q.size() > 0) ? 1 : 0);
      if (exp_q.size() > 0) begin
        e = exp_q[0];
        chk("rnd_result", rsp_result, e[W-1:0]);
        chk("rnd_ovf", rsp_ovf, e[W]);
      end
      chk("rnd_txn", txn_count, exp_txn[15:0]);
      v = ($urandom_range(0, 99) < 60);
      r = ($urandom_range(0, 99) < 50);
      a = rand_operand();
      b = rand_operand();
      drive_req(v, a, b);
      rsp_ready = r;
      begin
        bit can_push;
        can_push = (exp_q.size() < DEPTH);
        if (r && exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          exp_txn++;
        end
        if (v && can_push) exp_q.push_back(ref_add(a, b));
      end
      step();
    end
    drive_req(1'b0, '0, '0);
    rsp_ready = 1'b1;
    step();
    step();
    rsp_ready = 1'b0;
    chk("rnd_final_empty", rsp_valid, 0);

    // txn_count wrap: one response in flight, push+pop every edge.
    do_reset();
    drive_req(1'b1, 32'd1, 32'd2);
    step();
    rsp_ready = 1'b1;
    repeat (65535) step();
    chk("wrap_ffff", txn_count, 16'hFFFF);
    chk("wrap_valid", rsp_valid, 1);
    drive_req(1'b0, '0, '0);
    step();
    rsp_ready = 1'b0;
    chk("wrap_zero", txn_count, 16'h0000);
    chk("wrap_empty", rsp_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/add_responder.md
ADD_RESPONDER -- requirements
Module: add_responder

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits.
REQ-002 Parameter DEPTH, default 2, response buffer entries (power of two, >= 2).
REQ-003 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, reset, asynchronous and active-high.
REQ-005 Port req_valid, input, 1, requester has an operand pair on req_a/req_b.
REQ-006 Port req_ready, output, 1, the block can accept a request this cycle.
REQ-007 Port req_a, input, WIDTH, first signed operand.
REQ-008 Port req_b, input, WIDTH, second signed operand.
REQ-009 Port rsp_valid, output, 1, rsp_result/rsp_ovf hold a valid response.
REQ-010 Port rsp_ready, input, 1, consumer takes the response this cycle.
REQ-011 Port rsp_result, output, WIDTH, sum req_a+req_b modulo 2^WIDTH.
REQ-012 Port rsp_ovf, output, 1, two's-complement signed overflow of that sum.
REQ-013 Port txn_count, output, 16, count of completed response handshakes.

Function
REQ-014 Request accepted (push) iff req_valid && req_ready on a rising clk edge.
REQ-015 Response retired (pop) iff rsp_valid && rsp_ready on a rising clk edge.
REQ-016 Sum computed combinationally at acceptance and stored with its ovf bit; no arithmetic on the output side.
REQ-017 rsp_ovf = 1 iff req_a and req_b share a sign bit and the sum's sign bit differs; carry-out discarded.
REQ-018 Latency: response for a request accepted at edge N is visible with rsp_valid=1 after edge N; no combinational path from req_* to rsp_*.
REQ-019 Responses returned strictly in acceptance order.
REQ-020 Buffer occupancy FSM with states EMPTY (0), PARTIAL (1..DEPTH-1), FULL (DEPTH).
REQ-021 Transitions: push-only increments occupancy; pop-only decrements; push+pop same edge leaves occupancy unchanged.
REQ-022 req_ready = 1 iff state != FULL; registered-state decode only, no dependence on rsp_ready.
REQ-023 rsp_valid = 1 iff state != EMPTY; rsp_result/rsp_ovf show the head entry.
REQ-024 While rsp_valid=1 and rsp_ready=0, rsp_result and rsp_ovf stay stable.
REQ-025 Read and write pointers wrap from DEPTH-1 to 0.
REQ-026 In FULL with rsp_ready=1: pop occurs, no push that edge; state becomes PARTIAL.
REQ-027 In EMPTY, rsp_ready is ignored; occupancy never underflows.
REQ-028 txn_count increments by 1 on each pop, wraps 0xFFFF -> 0x0000.
REQ-029 req_a/req_b values while req_ready=0 or req_valid=0 have no effect.

Reset
REQ-030 rst=1 asynchronously forces state EMPTY, both pointers 0, txn_count 0, rsp_valid 0, rsp_result 0, rsp_ovf 0, req_ready 1.
REQ-031 Reset mid-operation discards all buffered responses; none are emitted after rst deasserts.
REQ-032 Buffer storage array need not be reset; only its visible outputs are zeroed via the EMPTY state.

Structure
REQ-033 Shared package add_pkg holds WIDTH default, the response struct type (result, ovf) and the add-with-overflow function used at acceptance.
REQ-034 One sub-module add_rsp_fifo: synchronous-write, DEPTH-entry, response-struct-wide FIFO with push/pop/full/empty; add_responder holds the adder, handshake decode and txn_count.

Verification
REQ-035 Push a=10, b=20, rsp_ready=1 -> next cycle rsp_valid=1, rsp_result=30, rsp_ovf=0; following cycle txn_count=1, rsp_valid=0.
REQ-036 Push a=0x7FFFFFFF, b=1 -> rsp_result=0x80000000, rsp_ovf=1; a=0xFFFFFFFF, b=1 -> rsp_result=0, rsp_ovf=0.
REQ-037 rsp_ready=0, push 1+1, 2+2 -> req_ready=0 after the second push; third request (3+3) held until rsp_ready=1; results exit 2,4,6 in order.
REQ-038 Occupancy 1, push 5+5 and pop on the same edge -> occupancy stays 1, head becomes 10, txn_count +1.
REQ-039 Two responses buffered, assert rst between clock edges -> rsp_valid=0, req_ready=1, txn_count=0 immediately; no stale result after release.
REQ-040 Preload txn_count to 0xFFFF via 65535 transactions, one more pop -> txn_count=0x0000.
